// File: rtl/comm_pkg.sv
// Shared types and constants for the copter command link: frame FSM states,
// command opcodes and the positive-acknowledge response byte.
package comm_pkg;

  typedef enum logic [1:0] {
    WAIT_CMD = 2'd0,
    WAIT_HI  = 2'd1,
    WAIT_LO  = 2'd2
  } frame_state_t;

  localparam logic [7:0] REQ_BATT  = 8'h01;
  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;
  localparam logic [7:0] POS_ACK   = 8'hA5;

endpackage

// File: rtl/uart_byte_trx.sv
// Bit-level UART engines: 8N1 receiver with mid-bit sampling and glitch-rejecting
// start check, plus an independent 8N1 transmitter.
module uart_byte_trx import comm_pkg::*; #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic       o_tx,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_vld,
  output logic       o_rx_start,
  output logic       o_rx_err,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_busy,
  output logic       o_tx_done
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] CNT_ZERO  = BW'(0);
  localparam logic [BW-1:0] CNT_ONE   = BW'(1);

  logic          r_rx_meta, r_rx_sync, r_rx_prev;
  logic          r_rx_busy;
  logic [BW-1:0] r_rx_cnt;
  logic [3:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic [7:0]    r_rx_byte;
  logic          r_rx_vld, r_rx_start, r_rx_err;

  logic          r_tx;
  logic          r_tx_busy, r_tx_done;
  logic [BW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bit;
  logic [8:0]    r_tx_shift;

  // Synchroniser plus one history flop for falling-edge detection; idle-high after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // Receiver: bit 0 is the start check, bits 1..8 data (LSB first), bit 9 the stop sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_busy  <= 1'b0;
      r_rx_cnt   <= CNT_ZERO;
      r_rx_bit   <= 4'd0;
      r_rx_shift <= 8'h00;
      r_rx_byte  <= 8'h00;
      r_rx_vld   <= 1'b0;
      r_rx_start <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_rx_vld   <= 1'b0;
      r_rx_start <= 1'b0;
      r_rx_err   <= 1'b0;
      if (!r_rx_busy) begin
        if (r_rx_prev && !r_rx_sync) begin
          r_rx_busy <= 1'b1;
          r_rx_cnt  <= BAUD_HALF;
          r_rx_bit  <= 4'd0;
        end
      end else if (r_rx_cnt != CNT_ZERO) begin
        r_rx_cnt <= r_rx_cnt - CNT_ONE;
      end else begin
        r_rx_cnt <= BAUD_LAST;
        r_rx_bit <= r_rx_bit + 4'd1;
        if (r_rx_bit == 4'd0) begin
          if (r_rx_sync) r_rx_busy  <= 1'b0;
          else           r_rx_start <= 1'b1;
        end else if (r_rx_bit == 4'd9) begin
          r_rx_busy <= 1'b0;
          if (r_rx_sync) begin
            r_rx_vld  <= 1'b1;
            r_rx_byte <= r_rx_shift;
          end else begin
            r_rx_err  <= 1'b1;
          end
        end else begin
          r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
        end
      end
    end
  end

  // Transmitter: the start bit is driven at acceptance, the shifter then supplies data and stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx       <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_cnt   <= CNT_ZERO;
      r_tx_bit   <= 4'd0;
      r_tx_shift <= 9'h1FF;
    end else begin
      r_tx_done <= 1'b0;
      if (!r_tx_busy) begin
        if (i_tx_start) begin
          r_tx_busy  <= 1'b1;
          r_tx       <= 1'b0;
          r_tx_shift <= {1'b1, i_tx_byte};
          r_tx_cnt   <= BAUD_LAST;
          r_tx_bit   <= 4'd0;
        end
      end else if (r_tx_cnt != CNT_ZERO) begin
        r_tx_cnt <= r_tx_cnt - CNT_ONE;
      end else if (r_tx_bit == 4'd9) begin
        r_tx_busy <= 1'b0;
        r_tx_done <= 1'b1;
        r_tx      <= 1'b1;
      end else begin
        r_tx       <= r_tx_shift[0];
        r_tx_shift <= {1'b1, r_tx_shift[8:1]};
        r_tx_cnt   <= BAUD_LAST;
        r_tx_bit   <= r_tx_bit + 4'd1;
      end
    end
  end

  assign o_tx       = r_tx;
  assign o_rx_byte  = r_rx_byte;
  assign o_rx_vld   = r_rx_vld;
  assign o_rx_start = r_rx_start;
  assign o_rx_err   = r_rx_err;
  assign o_tx_busy  = r_tx_busy;
  assign o_tx_done  = r_tx_done;

endmodule

// File: rtl/cmd_frame_uart.sv
// Copter-side command link: assembles 3-byte command frames from the UART into
// cmd/data with a ready flag, and sends single response bytes back.
module cmd_frame_uart import comm_pkg::*; #(
  parameter int BAUD_DIV    = 2604,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        tx_busy,
  output logic        resp_sent,
  output logic        frm_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_ZERO = TW'(0);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  logic [7:0]   w_rx_byte;
  logic         w_rx_vld, w_rx_start, w_rx_err;
  logic         w_tx_busy, w_tx_start;
  frame_state_t r_state, w_next;
  logic         w_ld_cmd, w_ld_hi, w_done;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]   r_cmd_sh, r_hi_sh, r_cmd;
  logic [15:0]  r_data;
  logic         r_cmd_rdy, r_frm_err;

  assign w_tx_start = send_resp & ~w_tx_busy;

  uart_byte_trx #(.BAUD_DIV(BAUD_DIV)) u_trx (
    .clk        (clk),
    .rst        (rst),
    .i_rx       (RX),
    .o_tx       (TX),
    .o_rx_byte  (w_rx_byte),
    .o_rx_vld   (w_rx_vld),
    .o_rx_start (w_rx_start),
    .o_rx_err   (w_rx_err),
    .i_tx_start (w_tx_start),
    .i_tx_byte  (resp),
    .o_tx_busy  (w_tx_busy),
    .o_tx_done  (resp_sent)
  );

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= WAIT_CMD;
    else     r_state <= w_next;
  end

  // A bad stop bit always resynchronises; a stalled partial frame is dropped on timeout.
  always_comb begin
    w_next   = r_state;
    w_ld_cmd = 1'b0;
    w_ld_hi  = 1'b0;
    w_done   = 1'b0;
    if (w_rx_err) begin
      w_next = WAIT_CMD;
    end else if (w_rx_vld) begin
      case (r_state)
        WAIT_CMD: begin w_ld_cmd = 1'b1; w_next = WAIT_HI;  end
        WAIT_HI:  begin w_ld_hi  = 1'b1; w_next = WAIT_LO;  end
        WAIT_LO:  begin w_done   = 1'b1; w_next = WAIT_CMD; end
        default:  begin w_next   = WAIT_CMD; end
      endcase
    end else if (r_state != WAIT_CMD && r_to_cnt == TO_MAX) begin
      w_next = WAIT_CMD;
    end else begin
      w_next = r_state;
    end
  end

  // Inter-byte idle counter; saturates at the timeout value.
  always_ff @(posedge clk) begin
    if (rst)                                                r_to_cnt <= TO_ZERO;
    else if (r_state == WAIT_CMD || w_rx_vld || w_rx_start) r_to_cnt <= TO_ZERO;
    else if (r_to_cnt != TO_MAX)                            r_to_cnt <= r_to_cnt + TO_ONE;
  end

  // Shadows and published outputs; cmd/data move only when a frame completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_sh  <= 8'h00;
      r_hi_sh   <= 8'h00;
      r_cmd     <= 8'h00;
      r_data    <= 16'h0000;
      r_cmd_rdy <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      if (w_ld_cmd) r_cmd_sh <= w_rx_byte;
      if (w_ld_hi)  r_hi_sh  <= w_rx_byte;
      if (w_done) begin
        r_cmd  <= r_cmd_sh;
        r_data <= {r_hi_sh, w_rx_byte};
      end
      if (w_done)                                                  r_cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy || (w_rx_start && r_state == WAIT_CMD)) r_cmd_rdy <= 1'b0;
      if (w_rx_err) r_frm_err <= 1'b1;
    end
  end

  assign cmd     = r_cmd;
  assign data    = r_data;
  assign cmd_rdy = r_cmd_rdy;
  assign frm_err = r_frm_err;
  assign tx_busy = w_tx_busy;

endmodule

// File: tb/tb_cmd_frame_uart.sv
// Self-checking bench for cmd_frame_uart: frame table, directed corner cases
// (timeout, framing error, TX, reset) and a random byte stream against a frame model.
module tb_cmd_frame_uart;

  localparam int B  = 16;
  localparam int TO = 400;

  logic        clk = 1'b0;
  logic        rst, RX, TX, cmd_rdy, clr_cmd_rdy, send_resp, tx_busy, resp_sent, frm_err;
  logic [7:0]  cmd, resp;
  logic [15:0] data;

  int checks = 0;
  int errors = 0;
  int rises  = 0;
  bit mon_en = 1'b0;
  logic [23:0] exp_q[$];

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic        clr;
    logic [7:0]  ecmd;
    logic [15:0] edata;
  } vec_t;
  vec_t tbl[4];

  always #5 clk = ~clk;

  cmd_frame_uart #(.BAUD_DIV(B), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .data(data),
    .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .resp(resp),
    .send_resp(send_resp), .tx_busy(tx_busy), .resp_sent(resp_sent), .frm_err(frm_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; bit-bangs one 8N1 byte, then idles high for gap cycles.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int gap);
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (B) @(negedge clk);
    end
    RX = stop_ok;
    repeat (B) @(negedge clk);
    RX = 1'b1;
    if (!stop_ok) repeat (B) @(negedge clk);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b1, 4);
    send_byte(b1, 1'b1, 4);
    send_byte(b2, 1'b1, 0);
  endtask

  task automatic wait_rdy(input string name);
    int n = 0;
    while (!cmd_rdy && n < 4 * B) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, cmd_rdy}, 32'd1);
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
  endtask

  // Counts cmd_rdy rises; in the random phase each rise must match the model's next frame.
  initial begin
    logic prev = 1'b0;
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (cmd_rdy === 1'b1 && prev !== 1'b1) begin
        rises++;
        if (mon_en) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rand_extra_frame: got cmd=%h data=%h, expected no frame", cmd, data);
          end else begin
            e = exp_q.pop_front();
            chk("rand_frame", {8'h00, cmd, data}, {8'h00, e});
          end
        end
      end
      prev = cmd_rdy;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, pulses, pulse_at, m_idx;
    logic [9:0] tx_seq;
    logic [7:0] rb, m_cmd, m_hi;
    logic rok, m_err;
    int gap;

    tbl[0] = '{8'h06, 8'h00, 8'h00, 1'b1, 8'h06, 16'h0000};
    tbl[1] = '{8'h02, 8'h00, 8'h2A, 1'b0, 8'h02, 16'h002A};
    tbl[2] = '{8'h04, 8'hFF, 8'h1F, 1'b1, 8'h04, 16'hFF1F};
    tbl[3] = '{8'h08, 8'h12, 8'h34, 1'b1, 8'h08, 16'h1234};
    tx_seq = 10'b1101001010;

    rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, TX}, 32'd1);
    chk("rst_cmd", {24'd0, cmd}, 32'd0);
    chk("rst_data", {16'd0, data}, 32'd0);
    chk("rst_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_sent", {31'd0, resp_sent}, 32'd0);
    chk("rst_ferr", {31'd0, frm_err}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      send_byte(tbl[i].b0, 1'b1, 4);
      if (i > 0 && !tbl[i-1].clr) begin
        chk("tbl_rdy_drop", {31'd0, cmd_rdy}, 32'd0);
        chk("tbl_cmd_hold", {24'd0, cmd}, {24'd0, tbl[i-1].ecmd});
      end
      send_byte(tbl[i].b1, 1'b1, 4);
      send_byte(tbl[i].b2, 1'b1, 0);
      wait_rdy("tbl_rdy");
      chk("tbl_cmd", {24'd0, cmd}, {24'd0, tbl[i].ecmd});
      chk("tbl_data", {16'd0, data}, {16'd0, tbl[i].edata});
      if (tbl[i].clr) begin
        pulse_clr();
        chk("tbl_clr", {31'd0, cmd_rdy}, 32'd0);
      end
    end

    r0 = rises;
    send_byte(8'h03, 1'b1, TO + 10);
    send_frame(8'h05, 8'h01, 8'h80);
    wait_rdy("to_rdy");
    chk("to_cmd", {24'd0, cmd}, 32'h05);
    chk("to_data", {16'd0, data}, 32'h0180);
    chk("to_one_rise", rises - r0, 32'd1);
    pulse_clr();

    r0 = rises;
    send_byte(8'h03, 1'b0, 4);
    send_frame(8'h03, 8'h00, 8'h3A);
    wait_rdy("fe_rdy");
    chk("fe_err", {31'd0, frm_err}, 32'd1);
    chk("fe_cmd", {24'd0, cmd}, 32'h03);
    chk("fe_data", {16'd0, data}, 32'h003A);
    chk("fe_one_rise", rises - r0, 32'd1);
    pulse_clr();

    resp = 8'hA5; send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    chk("tx_busy_set", {31'd0, tx_busy}, 32'd1);
    pulses = 0; pulse_at = -1;
    for (int c = 0; c <= 12 * B; c++) begin
      if (c % B == B / 2 && c / B < 10)
        chk($sformatf("tx_bit%0d", c / B), {31'd0, TX}, {31'd0, tx_seq[c / B]});
      if (c == 10 * B + B / 2) chk("tx2_start", {31'd0, TX}, 32'd0);
      if (c == 11 * B + B / 2 + 1) chk("tx2_bit0", {31'd0, TX}, 32'd1);
      if (resp_sent) begin
        pulses++;
        pulse_at = c;
      end
      send_resp = (c == 3 * B + 3) || (c == 10 * B);
      if (c == 3 * B + 3) resp = 8'h3C;
      if (c == 10 * B) resp = 8'h0F;
      @(negedge clk);
    end
    send_resp = 1'b0;
    chk("tx_one_pulse", pulses, 32'd1);
    chk("tx_pulse_time", pulse_at, 10 * B);
    chk("tx2_busy", {31'd0, tx_busy}, 32'd1);
    for (int n = 0; n < 12 * B && tx_busy; n++) @(negedge clk);
    chk("tx2_done", {31'd0, tx_busy}, 32'd0);

    send_byte(8'h08, 1'b1, 4);
    resp = 8'h55; send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    fork
      send_byte(8'hFF, 1'b1, 4);
      begin
        repeat (5 * B) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_tx", {31'd0, TX}, 32'd1);
        chk("mrst_busy", {31'd0, tx_busy}, 32'd0);
        chk("mrst_rdy", {31'd0, cmd_rdy}, 32'd0);
        chk("mrst_sent", {31'd0, resp_sent}, 32'd0);
        chk("mrst_ferr", {31'd0, frm_err}, 32'd0);
        chk("mrst_cmd", {24'd0, cmd}, 32'd0);
        chk("mrst_data", {16'd0, data}, 32'd0);
      end
    join
    send_frame(8'h08, 8'h00, 8'h00);
    wait_rdy("mrst_rdy2");
    chk("mrst_cmd2", {24'd0, cmd}, 32'h08);
    chk("mrst_data2", {16'd0, data}, 32'h0000);
    pulse_clr();

    // Random stream: frames are consecutive good bytes, broken by bad stops or long idles.
    exp_q.delete();
    mon_en = 1'b1;
    m_idx = 0; m_err = 1'b0; m_cmd = 8'h00; m_hi = 8'h00;
    for (int n = 0; n < 40; n++) begin
      rb  = 8'($urandom);
      rok = ($urandom_range(9) != 0);
      gap = ($urandom_range(7) == 0) ? TO + 50 + int'($urandom_range(100))
                                     : 4 + int'($urandom_range(80));
      if (!rok) begin
        m_idx = 0;
        m_err = 1'b1;
      end else if (m_idx == 0) begin
        m_cmd = rb; m_idx = 1;
      end else if (m_idx == 1) begin
        m_hi = rb; m_idx = 2;
      end else begin
        exp_q.push_back({m_cmd, m_hi, rb});
        m_idx = 0;
      end
      if (gap > TO) m_idx = 0;
      send_byte(rb, rok, gap);
    end
    repeat (2 * B) @(negedge clk);
    mon_en = 1'b0;
    chk("rand_all_frames", exp_q.size(), 32'd0);
    chk("rand_frm_err", {31'd0, frm_err}, {31'd0, m_err});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmd_frame_uart.md
Name: cmd_frame_uart

Overview:
Copter-side end of the wireless command link. Deserialises 3-byte command frames (cmd, data_hi, data_lo) arriving on RX into cmd/data with a cmd_rdy flag for the flight command handler. Serialises one 8-bit response byte (ack or battery reading) back on TX. Sits between the RX/TX pins and the command-processing FSM inside QuadCopter.

Parameters:
BAUD_DIV, 2604, clk cycles per bit (50 MHz / 19200 baud)
TIMEOUT_CYC, 1_000_000, max idle clk cycles between bytes of one frame before resync (20 ms)

Ports:
clk  in  1  system clock
rst  in  1  reset
RX  in  1  serial in, idle high, asynchronous to clk
TX  out  1  serial out, idle high
cmd  out  8  opcode of last complete frame
data  out  16  payload of last complete frame, {byte2, byte3}
cmd_rdy  out  1  complete frame available
clr_cmd_rdy  in  1  consumer acknowledge
resp  in  8  response byte to send
send_resp  in  1  start response transmission
tx_busy  out  1  transmitter active
resp_sent  out  1  one-cycle pulse when the stop bit of resp completes
frm_err  out  1  sticky; set on any bad stop bit; cleared only by rst

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: TX=1, cmd=0, data=0, cmd_rdy=0, tx_busy=0, resp_sent=0, frm_err=0. Frame FSM goes to WAIT_CMD. Both bit engines go idle.
- Reset mid-operation: any partial RX byte, partial frame or TX byte is abandoned. TX returns high on the reset edge.
- RX input: double-flop synchronised before use.
- RX start bit: a falling edge of the synchronised RX while idle.
- RX bit sampling:
  - Samples at BAUD_DIV/2 after the start edge, then every BAUD_DIV.
  - Start-bit sample must read 0, else the event is treated as a glitch and the engine returns to idle.
  - 8 data bits, LSB first, then the stop-bit sample.
- Stop bit: 1 means a valid byte is delivered to the frame FSM. 0 means the byte is discarded, frm_err is set and the frame FSM returns to WAIT_CMD.
- Frame FSM:
  - WAIT_CMD -> WAIT_HI on a valid byte, which loads a cmd shadow register.
  - WAIT_HI -> WAIT_LO on a valid byte, which loads the hi shadow.
  - WAIT_LO -> WAIT_CMD on a valid byte. cmd and data are updated from the shadows and this byte in the same cycle; cmd_rdy=1 from the next cycle.
- Timeout: in WAIT_HI or WAIT_LO, a counter counts cycles since the last valid byte. It reaches TIMEOUT_CYC -> WAIT_CMD with no outputs changed. The counter restarts on each RX start bit.
- cmd_rdy clearing: cleared on clr_cmd_rdy, or on detection of the start bit of the first byte of a new frame.
  - Frame completion and clr_cmd_rdy in the same cycle: set wins.
  - A new frame while cmd_rdy=1 overwrites cmd/data.
- cmd/data update: change only on frame completion; stable while cmd_rdy=1 unless a frame completes.
- TX:
  - send_resp while tx_busy=0 latches resp, drives the start bit from the next cycle, and sets tx_busy.
  - Frame sent: start bit 0, resp[0..7], stop bit 1, each BAUD_DIV cycles.
  - At the end of the stop bit: tx_busy=0 and resp_sent is pulsed in the same cycle.
  - send_resp while tx_busy=1 is ignored (no queueing).
  - send_resp in the cycle resp_sent pulses is accepted.
- RX and TX are fully independent (full duplex).
- Bit and baud counters must be wide enough for the parameters: $clog2(BAUD_DIV) bits and $clog2(TIMEOUT_CYC+1) bits.

Decomposition:
- Package comm_pkg holds:
  - frame_state_t enum {WAIT_CMD, WAIT_HI, WAIT_LO};
  - opcode constants REQ_BATT=8'h01, SET_PTCH=8'h02, SET_ROLL=8'h03, SET_YAW=8'h04, SET_THRST=8'h05, CALIBRATE=8'h06, EMER_LAND=8'h07, MTRS_OFF=8'h08;
  - POS_ACK=8'hA5.
- One sub-module, uart_byte_trx: the bit-level RX/TX engines with rx_byte/rx_vld/rx_start/rx_err and tx_start/tx_byte/tx_done. The frame FSM, timeout and flags live in cmd_frame_uart.

Test Plan:
- Send bytes 06,00,00 -> cmd=8'h06, data=16'h0000, cmd_rdy=1 one cycle after the last stop-bit sample. Pulse clr_cmd_rdy -> cmd_rdy=0.
- Send 02,00,2A then 04,FF,1F without clearing -> after the first frame cmd=02/data=002A. cmd_rdy drops at the start bit of the 04 byte and reasserts with cmd=04/data=FF1F.
- Send 03, idle TIMEOUT_CYC+10 cycles, then 05,01,80 -> cmd=8'h05, data=16'h0180. The stale 03 must not appear in cmd.
- Send byte 03 with stop bit forced 0, then 03,00,3A -> frm_err=1, cmd=8'h03, data=16'h003A, exactly one cmd_rdy rise.
- Pulse send_resp with resp=8'hA5, and pulse send_resp again mid-byte -> TX sequence 0,1,0,1,0,0,1,0,1,1 at BAUD_DIV spacing. A single resp_sent pulse 10*BAUD_DIV cycles after start; second request ignored.
- Assert rst mid-RX-byte and mid-TX -> TX=1 and all flags 0 on the next edge. A following clean frame 08,00,00 decodes to cmd=8'h08.
